// File: rtl/mem_reinit_pkg.sv
// ---------------------------------------------------------------------------
// mem_reinit_pkg : shared FSM state type and skid FIFO depth for mem_dump_reader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_reinit_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int SKID_DEPTH = 2;

endpackage

`default_nettype wire

// File: rtl/mem_dump_skid.sv
// ---------------------------------------------------------------------------
// mem_dump_skid : 2-entry FIFO whose head register drives the stream outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_dump_skid #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  input  logic         pop,
  output logic [1:0]   count,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         last
);

  logic [W-1:0] nxt_data;
  logic         nxt_last;

  assign valid = (count != 2'd0);

  // Entry 0 is the head register itself, so the stream outputs come straight off flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= 2'd0;
      data     <= '0;
      last     <= 1'b0;
      nxt_data <= '0;
      nxt_last <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            data <= push_data;
            last <= push_last;
          end else begin
            nxt_data <= push_data;
            nxt_last <= push_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          data  <= nxt_data;
          last  <= nxt_last;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            data <= push_data;
            last <= push_last;
          end else begin
            data     <= nxt_data;
            last     <= nxt_last;
            nxt_data <= push_data;
            nxt_last <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_dump_reader.sv
// ---------------------------------------------------------------------------
// mem_dump_reader : sweeps the attached RAM and streams every word over valid/ready.
// Optional trailing XOR checksum beat when MEM_DUMP_READER_CHECKSUM_EN is defined.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_dump_reader
  import mem_reinit_pkg::*;
#(
  parameter int WID_MEM   = 4,
  parameter int DEPTH_MEM = 8192,
  parameter int ADDR_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  mem_raddr,
  input  logic [WID_MEM-1:0] mem_dout,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WID_MEM-1:0] m_data,
  output logic               m_last
);

  localparam int            AW        = (DEPTH_MEM > 1) ? $clog2(DEPTH_MEM) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH_MEM - 1);

  state_t             state;
  logic [AW-1:0]      addr;
  logic               inflight;
  logic [1:0]         count;
  logic               pop;
  logic               issue;
  logic [2:0]         occ;
  logic               push;
  logic [WID_MEM-1:0] push_data;
  logic               push_last;

  assign pop       = m_valid & m_ready;
  // A beat leaving this cycle frees its slot, which is what sustains one read per cycle.
  assign occ       = 3'(count) + 3'(inflight) - 3'(pop);
  assign issue     = (state == RUN) && (occ < 3'(SKID_DEPTH));
  assign mem_raddr = ADDR_W'(addr);

`ifdef MEM_DUMP_READER_CHECKSUM_EN
  logic [WID_MEM-1:0] csum;
  logic               csum_push;

  // The checksum is final once the last read has landed in the FIFO.
  assign csum_push = (state == DRAIN) && !inflight && ((count < 2'(SKID_DEPTH)) || pop);
  assign push      = inflight | csum_push;
  assign push_data = inflight ? mem_dout : csum;
  assign push_last = csum_push;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum <= '0;
    end else if (state == IDLE && start) begin
      csum <= '0;
    end else if (inflight) begin
      csum <= csum ^ mem_dout;
    end
  end
`else
  logic inflight_last;

  assign push      = inflight;
  assign push_data = mem_dout;
  assign push_last = inflight_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_last <= 1'b0;
    end else begin
      inflight_last <= issue && (addr == LAST_ADDR);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      addr     <= '0;
      inflight <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        addr <= (addr == LAST_ADDR) ? '0 : addr + AW'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            addr  <= '0;
          end
        end
        RUN: begin
          if (issue && (addr == LAST_ADDR)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
`ifdef MEM_DUMP_READER_CHECKSUM_EN
          if (csum_push) begin
            state <= CSUM;
          end
`else
          if (pop && m_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
`endif
        end
        CSUM: begin
          if (pop && m_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mem_dump_skid #(.W(WID_MEM)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .push_last (push_last),
    .pop       (pop),
    .count     (count),
    .valid     (m_valid),
    .data      (m_data),
    .last      (m_last)
  );

endmodule

`default_nettype wire
